exec_sequencer: RTL and testbench

Multi-cycle control sequencer for the next-generation RV32 core top. It replaces the divided-clock single-cycle scheme with a single-clock state machine. The machine steps each instruction through fetch, execute, optional memory access and writeback, using valid/ready handshakes to the instruction and data buses. It gates all architectural write enables (PC, register file, CSR, memory), raises bus-error and timeout exceptions, and keeps cycle and retired-instruction counters.

---
 rtl/exec_seq_pkg.sv | 31 +++
 rtl/exec_sequencer_seq_wait_timer.sv | 25 ++
 rtl/exec_sequencer.sv | 144 ++++++++++++++
 tb/tb_exec_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/exec_seq_pkg.sv
// Shared types and default constants for the multi-cycle execution sequencer.
// Holds the state and exception-cause encodings used by the top FSM and the bench.
package exec_seq_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int TIMEOUT_W_DEF = 8;
  localparam int CNT_W_DEF     = 64;

  // Nine states (HALT included) do not fit in three bits, so the state code is four bits wide.
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_IDLE = 4'd0,
    ST_FETCH_REQ  = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_EXEC       = 4'd3,
    ST_MEM_REQ    = 4'd4,
    ST_MEM_WAIT   = 4'd5,
    ST_WB         = 4'd6,
    ST_TRAP       = 4'd7,
    ST_HALT       = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_FETCH_ERR = 2'd1,
    CAUSE_MEM_ERR   = 2'd2,
    CAUSE_TIMEOUT   = 2'd3
  } cause_e;

endpackage

// File: rtl/exec_sequencer_seq_wait_timer.sv
// Bus wait counter: cleared on entry to a wait state, counts cycles without a handshake.
// o_expired flags the last tolerated wait cycle (count 2^TIMEOUT_W-2), i.e. the (2^TIMEOUT_W-1)th wait.
module seq_wait_timer #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = {TIMEOUT_W{1'b1}} - 1'b1;

  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// Single-clock multi-cycle control sequencer: fetch, execute, optional memory, writeback.
// All strobes are decoded from the registered state; only inst_latch_en looks at the fetch response.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               o_ifu_req_valid,
  input  logic               i_ifu_req_ready,
  input  logic               i_ifu_rsp_valid,
  output logic               o_ifu_rsp_ready,
  input  logic               i_ifu_rsp_err,
  input  logic               i_is_load,
  input  logic               i_is_store,
  input  logic               i_halt_req,
  output logic               o_lsu_req_valid,
  input  logic               i_lsu_req_ready,
  input  logic               i_lsu_rsp_valid,
  output logic               o_lsu_rsp_ready,
  input  logic               i_lsu_rsp_err,
  output logic               o_inst_latch_en,
  output logic               o_pc_we,
  output logic               o_rd_we_en,
  output logic               o_csr_we_en,
  output logic               o_mem_we_en,
  output logic               o_exc_valid,
  output logic [1:0]         o_exc_cause,
  output logic               o_halted,
  output logic [STATE_W-1:0] o_state,
  output logic [CNT_W-1:0]   o_cycle_cnt,
  output logic [CNT_W-1:0]   o_instret_cnt
);

  state_e           r_state, w_next;
  cause_e           r_cause, w_cause_next;
  logic             r_store;
  logic [CNT_W-1:0] r_cycle, r_instret;
  logic             w_wait, w_hs, w_expired;

  seq_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_next != r_state),
    .i_inc     (w_wait && !w_hs),
    .o_expired (w_expired)
  );

  always_comb begin
    w_wait = 1'b0;
    w_hs   = 1'b0;
    unique case (r_state)
      ST_FETCH_REQ:  begin w_wait = 1'b1; w_hs = i_ifu_req_ready; end
      ST_FETCH_WAIT: begin w_wait = 1'b1; w_hs = i_ifu_rsp_valid; end
      ST_MEM_REQ:    begin w_wait = 1'b1; w_hs = i_lsu_req_ready; end
      ST_MEM_WAIT:   begin w_wait = 1'b1; w_hs = i_lsu_rsp_valid; end
      default:       ;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_cause_next = r_cause;
    unique case (r_state)
      ST_RESET_IDLE: w_next = ST_FETCH_REQ;
      ST_FETCH_REQ, ST_MEM_REQ: begin
        // A handshake on the terminal count still wins over the timeout.
        if (w_hs)           w_next = (r_state == ST_FETCH_REQ) ? ST_FETCH_WAIT : ST_MEM_WAIT;
        else if (w_expired) begin w_next = ST_TRAP; w_cause_next = CAUSE_TIMEOUT; end
      end
      ST_FETCH_WAIT: begin
        if (i_ifu_rsp_valid) begin
          if (i_ifu_rsp_err) begin w_next = ST_TRAP; w_cause_next = CAUSE_FETCH_ERR; end
          else                 w_next = ST_EXEC;
        end else if (w_expired) begin
          w_next = ST_TRAP; w_cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (i_halt_req)                   w_next = ST_HALT;
        else if (i_is_load || i_is_store) w_next = ST_MEM_REQ;
        else                              w_next = ST_WB;
      end
      ST_MEM_WAIT: begin
        if (i_lsu_rsp_valid) begin
          if (i_lsu_rsp_err) begin w_next = ST_TRAP; w_cause_next = CAUSE_MEM_ERR; end
          else                 w_next = ST_WB;
        end else if (w_expired) begin
          w_next = ST_TRAP; w_cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_WB:   w_next = ST_FETCH_REQ;
      ST_TRAP: begin w_next = ST_FETCH_REQ; w_cause_next = CAUSE_NONE; end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RESET_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RESET_IDLE;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_next;
    end
  end

  // Only the store flag matters past EXEC; load/halt already chose the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_store <= 1'b0;
    else if (r_state == ST_EXEC) r_store <= i_is_store;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (r_state != ST_RESET_IDLE && r_state != ST_HALT) r_cycle <= r_cycle + 1'b1;
      if (r_state == ST_WB) r_instret <= r_instret + 1'b1;
    end
  end

  assign o_ifu_req_valid = (r_state == ST_FETCH_REQ);
  assign o_ifu_rsp_ready = (r_state == ST_FETCH_WAIT);
  assign o_inst_latch_en = (r_state == ST_FETCH_WAIT) && i_ifu_rsp_valid && !i_ifu_rsp_err;
  assign o_lsu_req_valid = (r_state == ST_MEM_REQ);
  assign o_lsu_rsp_ready = (r_state == ST_MEM_WAIT);
  assign o_mem_we_en     = (r_state == ST_MEM_REQ) && r_store;
  assign o_pc_we         = (r_state == ST_WB) || (r_state == ST_TRAP);
  assign o_rd_we_en      = (r_state == ST_WB);
  assign o_csr_we_en     = (r_state == ST_WB);
  assign o_exc_valid     = (r_state == ST_TRAP);
  assign o_exc_cause     = r_cause;
  assign o_halted        = (r_state == ST_HALT);
  assign o_state         = r_state;
  assign o_cycle_cnt     = r_cycle;
  assign o_instret_cnt   = r_instret;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with TIMEOUT_W=3; all inputs change and outputs are sampled on negedge.
// Cycle 1 is the RESET_IDLE cycle in which rst is released.
module tb_exec_sequencer;

  logic clk = 1'b0, rst = 1'b1;
  logic ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, is_load, is_store, halt_req;
  logic lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic ifu_req_valid, ifu_rsp_ready, lsu_req_valid, lsu_rsp_ready;
  logic inst_latch_en, pc_we, rd_we_en, csr_we_en, mem_we_en, exc_valid, halted;
  logic [1:0]  exc_cause;
  logic [3:0]  state_o;
  logic [63:0] cycle_cnt, instret_cnt;
  int n_cmp = 0, n_fail = 0;

  // Bit order: ifu_req_v, ifu_rsp_r, latch, lsu_req_v, lsu_rsp_r, pc, rd, csr, mem, exc, halted
  localparam logic [10:0] O_NONE = 11'b00000000000, O_FR = 11'b10000000000;
  localparam logic [10:0] O_FW   = 11'b01100000000, O_FWE = 11'b01000000000;
  localparam logic [10:0] O_MRS  = 11'b00010000100, O_MRL = 11'b00010000000;
  localparam logic [10:0] O_MW   = 11'b00001000000, O_WB = 11'b00000111000;
  localparam logic [10:0] O_TRAP = 11'b00000100010, O_HALT = 11'b00000000001;

  wire [10:0] outs = {ifu_req_valid, ifu_rsp_ready, inst_latch_en, lsu_req_valid, lsu_rsp_ready,
                      pc_we, rd_we_en, csr_we_en, mem_we_en, exc_valid, halted};

  always #5 clk = ~clk;

  exec_sequencer #(.WIDTH(32), .TIMEOUT_W(3), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .o_ifu_req_valid(ifu_req_valid), .i_ifu_req_ready(ifu_req_ready),
    .i_ifu_rsp_valid(ifu_rsp_valid), .o_ifu_rsp_ready(ifu_rsp_ready), .i_ifu_rsp_err(ifu_rsp_err),
    .i_is_load(is_load), .i_is_store(is_store), .i_halt_req(halt_req),
    .o_lsu_req_valid(lsu_req_valid), .i_lsu_req_ready(lsu_req_ready),
    .i_lsu_rsp_valid(lsu_rsp_valid), .o_lsu_rsp_ready(lsu_rsp_ready), .i_lsu_rsp_err(lsu_rsp_err),
    .o_inst_latch_en(inst_latch_en), .o_pc_we(pc_we), .o_rd_we_en(rd_we_en),
    .o_csr_we_en(csr_we_en), .o_mem_we_en(mem_we_en), .o_exc_valid(exc_valid),
    .o_exc_cause(exc_cause), .o_halted(halted), .o_state(state_o),
    .o_cycle_cnt(cycle_cnt), .o_instret_cnt(instret_cnt)
  );

  task automatic clr_in();
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0; is_load = 0; is_store = 0;
    halt_req = 0; lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
  endtask

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at cycle 1 (rst just released, RESET_IDLE).
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clr_in();
    rst = 1'b1;
    nc(2);
    n_cmp++; if (outs !== O_NONE) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs, O_NONE); end
    n_cmp++; if ({state_o, exc_cause} !== 6'd0) begin n_fail++; $display("FAIL reset_state: got %0d/%0d want 0/0", state_o, exc_cause); end
    n_cmp++; if ({cycle_cnt, instret_cnt} !== 128'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_cnt, instret_cnt); end
  endtask

  task automatic test_alu();
    clr_in(); ifu_req_ready = 1; ifu_rsp_valid = 1;
    do_reset();
    n_cmp++; if (outs !== O_NONE) begin n_fail++; $display("FAIL alu_c1: got %b want %b", outs, O_NONE); end
    nc(1);
    n_cmp++; if (outs !== O_FR) begin n_fail++; $display("FAIL alu_c2: got %b want %b", outs, O_FR); end
    nc(1);
    n_cmp++; if (outs !== O_FW) begin n_fail++; $display("FAIL alu_c3_latch: got %b want %b", outs, O_FW); end
    nc(1);
    n_cmp++; if (outs !== O_NONE || state_o !== 4'd3) begin n_fail++; $display("FAIL alu_c4_exec: got %b st %0d want %b st 3", outs, state_o, O_NONE); end
    nc(1);
    n_cmp++; if (outs !== O_WB) begin n_fail++; $display("FAIL alu_c5_wb: got %b want %b", outs, O_WB); end
    nc(1);
    n_cmp++; if (instret_cnt !== 64'd1 || cycle_cnt !== 64'd4) begin n_fail++; $display("FAIL alu_c6_cnt: got instret %0d cycle %0d want 1 4", instret_cnt, cycle_cnt); end
    n_cmp++; if (state_o !== 4'd1) begin n_fail++; $display("FAIL alu_c6_state: got %0d want 1", state_o); end
  endtask

  task automatic test_store_delayed();
    clr_in(); ifu_req_ready = 1; ifu_rsp_valid = 1; is_store = 1; lsu_rsp_valid = 1;
    do_reset();
    nc(3);
    n_cmp++; if (outs !== O_NONE) begin n_fail++; $display("FAIL st_exec: got %b want %b", outs, O_NONE); end
    for (int k = 5; k <= 8; k++) begin
      nc(1);
      n_cmp++; if (outs !== O_MRS) begin n_fail++; $display("FAIL st_memreq_c%0d: got %b want %b", k, outs, O_MRS); end
    end
    lsu_req_ready = 1; is_store = 0;
    nc(1);
    n_cmp++; if (outs !== O_MW) begin n_fail++; $display("FAIL st_memwait: got %b want %b", outs, O_MW); end
    nc(1);
    n_cmp++; if (outs !== O_WB || instret_cnt !== 64'd0) begin n_fail++; $display("FAIL st_wb: got %b ir %0d want %b ir 0", outs, instret_cnt, O_WB); end
    nc(1);
    n_cmp++; if (outs !== O_FR || instret_cnt !== 64'd1) begin n_fail++; $display("FAIL st_after: got %b ir %0d want %b ir 1", outs, instret_cnt, O_FR); end
  endtask

  task automatic test_fetch_err();
    clr_in(); ifu_req_ready = 1; ifu_rsp_valid = 1; ifu_rsp_err = 1;
    do_reset();
    nc(2);
    n_cmp++; if (outs !== O_FWE) begin n_fail++; $display("FAIL ferr_nolatch: got %b want %b", outs, O_FWE); end
    nc(1);
    n_cmp++; if (outs !== O_TRAP || exc_cause !== 2'd1 || state_o !== 4'd7) begin n_fail++; $display("FAIL ferr_trap: got %b c%0d st%0d want %b c1 st7", outs, exc_cause, state_o, O_TRAP); end
    nc(1);
    n_cmp++; if (state_o !== 4'd1 || exc_cause !== 2'd0 || instret_cnt !== 64'd0) begin n_fail++; $display("FAIL ferr_after: got st%0d c%0d ir%0d want st1 c0 ir0", state_o, exc_cause, instret_cnt); end
  endtask

  task automatic test_timeout(input bit late_rsp);
    clr_in(); ifu_req_ready = 1; ifu_rsp_valid = 1; is_load = 1; lsu_req_ready = 1;
    do_reset();
    nc(4);
    n_cmp++; if (outs !== O_MRL) begin n_fail++; $display("FAIL to_memreq: got %b want %b", outs, O_MRL); end
    for (int k = 6; k <= 12; k++) begin
      nc(1);
      n_cmp++; if (state_o !== 4'd5) begin n_fail++; $display("FAIL to_wait_c%0d: got st%0d want st5", k, state_o); end
    end
    if (late_rsp) lsu_rsp_valid = 1;
    nc(1);
    if (late_rsp) begin
      n_cmp++; if (outs !== O_WB || exc_cause !== 2'd0) begin n_fail++; $display("FAIL to_edge_wb: got %b c%0d want %b c0", outs, exc_cause, O_WB); end
    end else begin
      n_cmp++; if (outs !== O_TRAP || exc_cause !== 2'd3) begin n_fail++; $display("FAIL to_trap: got %b c%0d want %b c3", outs, exc_cause, O_TRAP); end
    end
  endtask

  task automatic test_halt();
    clr_in(); ifu_req_ready = 1; ifu_rsp_valid = 1; halt_req = 1; is_load = 1;
    do_reset();
    nc(4);
    n_cmp++; if (outs !== O_HALT || state_o !== 4'd8 || cycle_cnt !== 64'd3) begin n_fail++; $display("FAIL halt_enter: got %b st%0d cy%0d want %b st8 cy3", outs, state_o, cycle_cnt, O_HALT); end
    halt_req = 0; is_load = 0; lsu_req_ready = 1; lsu_rsp_valid = 1;
    for (int k = 0; k < 20; k++) begin
      nc(1);
      n_cmp++; if (outs !== O_HALT || cycle_cnt !== 64'd3) begin n_fail++; $display("FAIL halt_hold_%0d: got %b cy%0d want %b cy3", k, outs, cycle_cnt, O_HALT); end
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (outs !== O_NONE || state_o !== 4'd0 || cycle_cnt !== 64'd0) begin n_fail++; $display("FAIL halt_rst: got %b st%0d cy%0d want %b st0 cy0", outs, state_o, cycle_cnt, O_NONE); end
  endtask

  task automatic test_reset_mid_mem();
    clr_in(); ifu_req_ready = 1; ifu_rsp_valid = 1; is_store = 1;
    do_reset();
    nc(4);
    n_cmp++; if (outs !== O_MRS) begin n_fail++; $display("FAIL rmid_pre: got %b want %b", outs, O_MRS); end
    #2 rst = 1'b1; lsu_rsp_valid = 1;
    #1;
    n_cmp++; if (lsu_req_valid !== 1'b0 || outs !== O_NONE) begin n_fail++; $display("FAIL rmid_drop: got %b want %b", outs, O_NONE); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (outs !== O_NONE || state_o !== 4'd0) begin n_fail++; $display("FAIL rmid_idle: got %b st%0d want %b st0", outs, state_o, O_NONE); end
    nc(1);
    n_cmp++; if (outs !== O_FR) begin n_fail++; $display("FAIL rmid_refetch: got %b want %b", outs, O_FR); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_delayed();
    test_fetch_err();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_halt();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
